// File: rtl/score_display.sv
// Score overlay renderer.
// Latches the game score once per frame, tracks the session high score and
// draws both as 4-digit 7-segment fields. pixel_on trails hpos/vpos by two
// clk cycles: stage 1 locates the pixel inside a digit box, stage 2 resolves
// which segment it falls on.
module score_display #(
  parameter int SCORE_X     = 560,
  parameter int SCORE_Y     = 16,
  parameter int HI_X        = 460,
  parameter int HI_Y        = 16,
  parameter int DIGIT_PITCH = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_tick,
  input  logic [15:0] score,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        video_active,
  output logic        pixel_on,
  output logic [15:0] hi_score
);

  // Result of locating one pixel inside one field.
  typedef struct packed {
    logic       hit;
    logic [3:0] dig;
    logic [3:0] lx;
    logic [4:0] ly;
  } loc_t;

  logic [15:0] disp_score;

  loc_t loc_sc, loc_hi;
  loc_t s1_sc, s1_hi;
  logic s1_active;

  // Replace suppressed leading zeros with code 15, which decodes to blank.
  // Digit 0 is never suppressed.
  function automatic logic [15:0] blank_lz(input logic [15:0] v);
    logic [15:0] r;
    logic        z3, z2, z1;
    r  = v;
    z3 = (v[15:12] == 4'd0);
    z2 = z3 && (v[11:8] == 4'd0);
    z1 = z2 && (v[7:4] == 4'd0);
    if (z3) r[15:12] = 4'hF;
    if (z2) r[11:8]  = 4'hF;
    if (z1) r[7:4]   = 4'hF;
    return r;
  endfunction

  // Find which digit box of a field (origin fx,fy) the pixel lies in, if any.
  function automatic loc_t locate(input logic [9:0] x, input logic [9:0] y,
                                  input int fx, input int fy,
                                  input logic [15:0] digs);
    loc_t r;
    int   xi, yi, x0;
    r  = '0;
    xi = int'(x);
    yi = int'(y);
    if (yi >= fy && yi <= fy + 23) begin
      for (int k = 0; k < 4; k++) begin
        x0 = fx + (3 - k) * DIGIT_PITCH;
        if (xi >= x0 && xi <= x0 + 15) begin
          r.hit = 1'b1;
          r.dig = digs[4*k +: 4];
          r.lx  = 4'(xi - x0);
          r.ly  = 5'(yi - fy);
        end
      end
    end
    return r;
  endfunction

  // Segment lookup for a digit at local coordinates; codes 10..15 are blank.
  function automatic logic seg_hit(input logic [3:0] dig, input logic [3:0] lx,
                                   input logic [4:0] ly);
    logic [6:0] s;  // {a,b,c,d,e,f,g}
    logic       mid_x, left_x, right_x;
    case (dig)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    mid_x   = (lx >= 4'd2) && (lx <= 4'd13);
    left_x  = (lx <= 4'd2);
    right_x = (lx >= 4'd13);
    return (s[6] && mid_x   && (ly <= 5'd2))
         | (s[5] && right_x && (ly >= 5'd2)  && (ly <= 5'd11))
         | (s[4] && right_x && (ly >= 5'd12) && (ly <= 5'd21))
         | (s[3] && mid_x   && (ly >= 5'd21) && (ly <= 5'd23))
         | (s[2] && left_x  && (ly >= 5'd12) && (ly <= 5'd21))
         | (s[1] && left_x  && (ly >= 5'd2)  && (ly <= 5'd11))
         | (s[0] && mid_x   && (ly >= 5'd10) && (ly <= 5'd12));
  endfunction

  // Frame capture of the displayed score and running high score.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_score <= '0;
      hi_score   <= '0;
    end else if (game_tick) begin
      disp_score <= score;
      if (score > hi_score) hi_score <= score;
    end
  end

  // Locate the current pixel in both fields.
  always_comb begin
    loc_sc = locate(hpos, vpos, SCORE_X, SCORE_Y, blank_lz(disp_score));
    loc_hi = locate(hpos, vpos, HI_X, HI_Y, blank_lz(hi_score));
  end

  // Stage 1: register box position, digit code and active flag per field.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_sc     <= '0;
      s1_hi     <= '0;
      s1_active <= 1'b0;
    end else begin
      s1_sc     <= loc_sc;
      s1_hi     <= loc_hi;
      s1_active <= video_active;
    end
  end

  // Stage 2: segment hit; overlapping fields simply OR together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_on <= 1'b0;
    end else begin
      pixel_on <= s1_active &&
                  ((s1_sc.hit && seg_hit(s1_sc.dig, s1_sc.lx, s1_sc.ly)) ||
                   (s1_hi.hit && seg_hit(s1_hi.dig, s1_hi.lx, s1_hi.ly)));
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: reset, capture latency, blanking,
// segment geometry, high-score tracking and mid-frame reset.
module tb_score_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        game_tick;
  logic [15:0] score;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        video_active;
  logic        pixel_on;
  logic [15:0] hi_score;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] sc;
    int          h;
    int          v;
    logic        act;
    logic        exp;
  } vec_t;

  typedef struct {
    logic [15:0] sc;
    logic [15:0] exp_hi;
  } hvec_t;

  vec_t  vecs[$];
  hvec_t hvecs[$];

  always #5 clk = ~clk;

  score_display dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .game_tick    (game_tick),
    .score        (score),
    .hpos         (hpos),
    .vpos         (vpos),
    .video_active (video_active),
    .pixel_on     (pixel_on),
    .hi_score     (hi_score)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic tick(input logic [15:0] s);
    score     = s;
    game_tick = 1'b1;
    @(posedge clk);
    #1;
    game_tick = 1'b0;
  endtask

  // Drive a pixel position and check pixel_on two edges later.
  task automatic pix(input string name, input int h, input int v, input logic act,
                     input logic exp);
    hpos         = 10'(h);
    vpos         = 10'(v);
    video_active = act;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk(name, {15'd0, pixel_on}, {15'd0, exp});
  endtask

  initial begin
    // score, hpos, vpos, active, expected pixel (current-score field at 560,16)
    vecs.push_back('{16'h0001, 634, 21, 1'b1, 1'b1});  // d0 seg b of "1"
    vecs.push_back('{16'h0001, 622, 17, 1'b1, 1'b0});  // d0 seg a not in "1"
    vecs.push_back('{16'h0001, 565, 17, 1'b1, 1'b0});  // d3 blanked
    vecs.push_back('{16'h1001, 565, 17, 1'b1, 1'b0});  // "1" lacks a
    vecs.push_back('{16'h1001, 574, 20, 1'b1, 1'b1});  // d3 seg b
    vecs.push_back('{16'h1001, 594, 20, 1'b1, 1'b1});  // d2 "0" kept
    vecs.push_back('{16'h0001, 594, 20, 1'b1, 1'b0});  // d2 "0" blanked
    vecs.push_back('{16'h0008, 627, 27, 1'b1, 1'b1});  // seg g of 8
    vecs.push_back('{16'h0000, 627, 27, 1'b1, 1'b0});  // 0 has no g
    vecs.push_back('{16'h0000, 621, 30, 1'b1, 1'b1});  // seg e of 0
    vecs.push_back('{16'h0005, 621, 30, 1'b1, 1'b0});  // 5 has no e
    vecs.push_back('{16'h0007, 634, 36, 1'b1, 1'b1});  // seg c of 7
    vecs.push_back('{16'h0002, 634, 36, 1'b1, 1'b0});  // 2 has no c
    vecs.push_back('{16'h0002, 627, 39, 1'b1, 1'b1});  // seg d bottom row
    vecs.push_back('{16'h000A, 627, 27, 1'b1, 1'b0});  // invalid code blank
    vecs.push_back('{16'h000A, 634, 21, 1'b1, 1'b0});
    vecs.push_back('{16'h000A, 627, 17, 1'b1, 1'b0});
    vecs.push_back('{16'h000A, 621, 30, 1'b1, 1'b0});
    vecs.push_back('{16'h0040, 614, 20, 1'b1, 1'b1});  // d1 "4" seg b
    vecs.push_back('{16'h0040, 634, 21, 1'b1, 1'b1});  // d0 "0" drawn
    vecs.push_back('{16'h0100, 614, 20, 1'b1, 1'b1});  // d1 "0" kept by d2
    vecs.push_back('{16'h0001, 634, 21, 1'b0, 1'b0});  // inactive video
    vecs.push_back('{16'h0008, 635, 21, 1'b1, 1'b1});  // right edge of box
    vecs.push_back('{16'h0008, 636, 21, 1'b1, 1'b0});  // just outside
    vecs.push_back('{16'h0008, 634, 40, 1'b1, 1'b0});  // below box
    vecs.push_back('{16'h0008, 634, 15, 1'b1, 1'b0});  // above box
    vecs.push_back('{16'h0008, 619, 21, 1'b1, 1'b0});  // gap between digits

    hvecs.push_back('{16'h0120, 16'h0120});
    hvecs.push_back('{16'h0450, 16'h0450});
    hvecs.push_back('{16'h0000, 16'h0450});
    hvecs.push_back('{16'h0300, 16'h0450});
    hvecs.push_back('{16'h9999, 16'h9999});
    hvecs.push_back('{16'h0000, 16'h9999});

    rst_n        = 1'b0;
    game_tick    = 1'b0;
    score        = 16'h1234;
    hpos         = 10'd634;
    vpos         = 10'd21;
    video_active = 1'b1;

    // Reset held with ticks and active video in a segment.
    for (int i = 0; i < 4; i++) begin
      game_tick = 1'b1;
      @(posedge clk);
      #1;
      game_tick = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("reset_pixel", {15'd0, pixel_on}, 16'd0);
    chk("reset_hi", hi_score, 16'h0000);

    rst_n = 1'b1;
    pix("post_reset_d0_zero_b", 634, 21, 1'b1, 1'b1);
    pix("post_reset_d0_no_g", 627, 27, 1'b1, 1'b0);
    pix("post_reset_d3_blank", 565, 17, 1'b1, 1'b0);
    pix("post_reset_d1_blank", 614, 20, 1'b1, 1'b0);

    // Table-driven pixel checks.
    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].sc);
      pix($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].act, vecs[i].exp);
    end

    // High score sequence from a clean reset.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("hi_after_reset", hi_score, 16'h0000);
    for (int i = 0; i < hvecs.size(); i++) begin
      tick(hvecs[i].sc);
      chk($sformatf("hi_seq%0d", i), hi_score, hvecs[i].exp_hi);
    end

    // No tick: neither register moves.
    score = 16'h5000;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("hi_hold_no_tick", hi_score, 16'h9999);
    pix("disp_hold_no_tick", 581, 17, 1'b1, 1'b0);  // displayed is still 0000

    // High-score field rendering (origin 460,16) showing 9999.
    pix("hi_field_d3_b", 474, 20, 1'b1, 1'b1);
    pix("hi_field_d3_no_e", 461, 30, 1'b1, 1'b0);
    pix("hi_field_d0_g", 527, 27, 1'b1, 1'b1);

    // Mid-frame reset on a lit segment.
    tick(16'h0008);
    pix("midreset_pre", 627, 27, 1'b1, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_pixel", {15'd0, pixel_on}, 16'd0);
    chk("midreset_hi", hi_score, 16'h0000);
    rst_n = 1'b1;
    pix("midreset_disp_cleared", 627, 27, 1'b1, 1'b0);
    pix("midreset_d0_zero", 634, 21, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Downstream consumer of the 4-digit packed-BCD game score.
- Captures the score once per frame and tracks the session high score.
- Renders both values as 7-segment digits on a 640x480 raster and emits a per-pixel on/off overlay to the video mixer.
- Pixel output is pipelined, 2 cycles behind hpos/vpos.

Parameters:
- SCORE_X, 560, left x of current-score field (digit 3 leftmost).
- SCORE_Y, 16, top y of current-score field.
- HI_X, 460, left x of high-score field.
- HI_Y, 16, top y of high-score field.
- DIGIT_PITCH, 20, x distance between digit origins.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; synchronous, active-low
- game_tick  input  1  end-of-frame pulse, one cycle
- score  input  16  packed BCD {d3,d2,d1,d0} from score counter
- hpos  input  10  current pixel x
- vpos  input  10  current pixel y
- video_active  input  1  high in visible region
- pixel_on  output  1  overlay pixel, registered
- hi_score  output  16  packed BCD high score, registered

Behaviour:
- Reset (rst_n low at clk edge): disp_score, hi_score, pipeline registers and pixel_on all 0. Reset mid-frame forces pixel_on to 0 from the next edge.
- Frame capture: on a clk edge with game_tick=1, disp_score <= score.
  - Same edge: if score > hi_score as 16-bit unsigned (valid for packed BCD), hi_score <= score.
  - game_tick=0: both registers hold.
  - The score counter updates on the same edge, so the displayed value lags it by one frame. This is intended.
  - hi_score is never cleared except by reset; a game restart does not clear it. Counter wrap 9999->0 leaves hi_score at 9999.
- Digit geometry: digit k (k=3..0) of a field with origin (FX,FY) occupies the box x in [FX+(3-k)*DIGIT_PITCH, +15] and y in [FY, FY+23]. Local coordinates are lx 0..15, ly 0..23.
- Segment rectangles (inclusive, local coordinates):
  - a: lx 2..13, ly 0..2
  - b: lx 13..15, ly 2..11
  - c: lx 13..15, ly 12..21
  - d: lx 2..13, ly 21..23
  - e: lx 0..2, ly 12..21
  - f: lx 0..2, ly 2..11
  - g: lx 2..13, ly 10..12
- Segment map:
  - 0 = abcdef
  - 1 = bc
  - 2 = abdeg
  - 3 = abcdg
  - 4 = bcfg
  - 5 = acdfg
  - 6 = acdefg
  - 7 = abc
  - 8 = abcdefg
  - 9 = abcdfg
  - codes 10..15 = blank
- Leading-zero blanking: digit k>0 is blanked if it and every more-significant digit are 0. Digit 0 is always drawn. Applies to both fields independently.
- Pipeline:
  - Stage 1 registers: in-box flag, field select, digit value, lx, ly, video_active.
  - Stage 2 registers pixel_on = stage-1 valid & active & segment hit.
  - Latency is exactly 2 clk cycles from hpos/vpos/video_active to pixel_on.
  - Digit values are taken from disp_score/hi_score at stage 1.
- Overlap: fields do not overlap with default parameters. If configured to overlap, pixel_on is the OR of both fields.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst_n=0 with game_tick pulses and active video -> pixel_on=0, hi_score=0x0000. Release -> pixel_on stays 0 while disp_score=0, except the always-drawn digit-0 "0" pixels.
- Capture and latency: score=0x0001, pulse game_tick, then drive hpos=634, vpos=21, video_active=1 -> pixel_on=1 exactly 2 cycles later (digit 0 segment b). hpos=622, vpos=17 -> 0 (segment a is not lit for "1").
- Leading-zero blanking: disp_score=0x0001, hpos=565, vpos=17 (digit 3 segment a) -> 0. disp_score=0x1001 at the same position -> 0 ("1" has no segment a). At hpos=574, vpos=20 -> 1 (digit 3 segment b). Digit 2 at hpos=594, vpos=20 -> 1 ("0" lit because digit 3 is nonzero).
- High score: tick sequence score=0x0120, 0x0450, 0x0000 (restart), 0x0300 -> hi_score 0x0120, 0x0450, 0x0450, 0x0450. score=0x9999 then 0x0000 -> hi_score stays 0x9999.
- Invalid BCD / blanking: score=0x000A ticked -> no pixel lit anywhere in the digit-0 box. With video_active=0 inside a lit segment -> pixel_on=0.
- Mid-frame reset: pixel_on=1 on a lit segment, assert rst_n=0 for one edge -> pixel_on=0 on that edge, disp_score and hi_score cleared.
